// File: rtl/axi_amo_sequencer.sv
// Executes one RISC-V AMO as a single-beat AXI read-modify-write and returns the old value.
// One operation is in flight at a time; every handshake output comes straight from a flop.
module axi_amo_sequencer #(
  parameter int AXI_ADDR_WIDTH   = 64,
  parameter int AXI_DATA_WIDTH   = 64,
  parameter int AXI_ID_WIDTH     = 4,
  parameter int RISCV_WORD_WIDTH = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [2:0]                req_size_i,
  input  logic [3:0]                req_op_i,
  input  logic [63:0]               req_operand_i,
  input  logic [AXI_ID_WIDTH-1:0]   req_id_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [63:0]               rsp_data_o,
  output logic                      rsp_err_o,
  output logic [AXI_ADDR_WIDTH-1:0] mst_ar_addr_o,
  output logic [2:0]                mst_ar_size_o,
  output logic [AXI_ID_WIDTH-1:0]   mst_ar_id_o,
  output logic                      mst_ar_valid_o,
  input  logic                      mst_ar_ready_i,
  input  logic [63:0]               mst_r_data_i,
  input  logic [1:0]                mst_r_resp_i,
  input  logic                      mst_r_last_i,
  input  logic                      mst_r_valid_i,
  output logic                      mst_r_ready_o,
  output logic [AXI_ADDR_WIDTH-1:0] mst_aw_addr_o,
  output logic [2:0]                mst_aw_size_o,
  output logic [AXI_ID_WIDTH-1:0]   mst_aw_id_o,
  output logic                      mst_aw_valid_o,
  input  logic                      mst_aw_ready_i,
  output logic [63:0]               mst_w_data_o,
  output logic [7:0]                mst_w_strb_o,
  output logic                      mst_w_last_o,
  output logic                      mst_w_valid_o,
  input  logic                      mst_w_ready_i,
  input  logic [1:0]                mst_b_resp_i,
  input  logic                      mst_b_valid_i,
  output logic                      mst_b_ready_o
);

  if (AXI_DATA_WIDTH != 64) begin : g_bad_data_width
    $fatal(1, "axi_amo_sequencer: AXI_DATA_WIDTH must be 64");
  end

  localparam logic ALLOW_DWORD = (RISCV_WORD_WIDTH == 64);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_AR = 3'd1, S_R = 3'd2, S_ALU = 3'd3,
    S_WR = 3'd4, S_B = 3'd5, S_RSP = 3'd6
  } state_e;

  // Word ops work on the low 32 bits; the compare inputs are widened per signedness.
  function automatic logic [63:0] amo_alu(input logic [3:0] op, input logic is_word,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [63:0] as_v, bs_v, au_v, bu_v, res_v;
    as_v = is_word ? {{32{a[31]}}, a[31:0]} : a;
    bs_v = is_word ? {{32{b[31]}}, b[31:0]} : b;
    au_v = is_word ? {32'd0, a[31:0]} : a;
    bu_v = is_word ? {32'd0, b[31:0]} : b;
    case (op)
      4'd0:    res_v = b;
      4'd1:    res_v = a + b;
      4'd2:    res_v = a & b;
      4'd3:    res_v = a | b;
      4'd4:    res_v = a ^ b;
      4'd5:    res_v = ($signed(as_v) > $signed(bs_v)) ? a : b;
      4'd6:    res_v = (au_v > bu_v) ? a : b;
      4'd7:    res_v = ($signed(as_v) < $signed(bs_v)) ? a : b;
      4'd8:    res_v = (au_v < bu_v) ? a : b;
      default: res_v = b;
    endcase
    return res_v;
  endfunction

  state_e                    state_r;
  logic [AXI_ADDR_WIDTH-1:0] addr_r;
  logic [2:0]                size_r;
  logic [3:0]                op_r;
  logic [63:0]               operand_r, old_r;
  logic [AXI_ID_WIDTH-1:0]   id_r;
  logic                      req_ready_r, rsp_valid_r, rsp_err_r;
  logic [63:0]               rsp_data_r, w_data_r;
  logic [7:0]                w_strb_r;
  logic                      ar_valid_r, r_ready_r, aw_valid_r, w_valid_r, b_ready_r;
  logic                      req_legal_s, is_word_s, aw_done_s, w_done_s, unused_s;
  logic [63:0]               lane_s, alu_s;

  assign is_word_s = (size_r == 3'd2);
  assign aw_done_s = !aw_valid_r || mst_aw_ready_i;
  assign w_done_s  = !w_valid_r || mst_w_ready_i;
  assign alu_s     = amo_alu(op_r, is_word_s, old_r, operand_r);
  assign unused_s  = ^{mst_r_last_i, mst_r_resp_i[0], mst_b_resp_i[0]};

  // Request legality: known op, supported size, naturally aligned address
  always_comb begin
    req_legal_s = 1'b0;
    if (req_op_i > 4'd8) begin
      req_legal_s = 1'b0;
    end else if (req_size_i == 3'd2) begin
      req_legal_s = (req_addr_i[1:0] == 2'b00);
    end else if (req_size_i == 3'd3) begin
      req_legal_s = ALLOW_DWORD && (req_addr_i[2:0] == 3'b000);
    end else begin
      req_legal_s = 1'b0;
    end
  end

  // Read lane extraction; word results are sign-extended for the response
  always_comb begin
    lane_s = mst_r_data_i;
    if (is_word_s) begin
      if (addr_r[2]) begin
        lane_s = {{32{mst_r_data_i[63]}}, mst_r_data_i[63:32]};
      end else begin
        lane_s = {{32{mst_r_data_i[31]}}, mst_r_data_i[31:0]};
      end
    end else begin
      lane_s = mst_r_data_i;
    end
  end

  // Sequencer FSM: request capture, AR, R, ALU, AW+W, B, response
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= S_IDLE;
      addr_r      <= {AXI_ADDR_WIDTH{1'b0}};
      size_r      <= 3'd0;
      op_r        <= 4'd0;
      operand_r   <= 64'd0;
      old_r       <= 64'd0;
      id_r        <= {AXI_ID_WIDTH{1'b0}};
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_data_r  <= 64'd0;
      w_data_r    <= 64'd0;
      w_strb_r    <= 8'd0;
      ar_valid_r  <= 1'b0;
      r_ready_r   <= 1'b0;
      aw_valid_r  <= 1'b0;
      w_valid_r   <= 1'b0;
      b_ready_r   <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (req_ready_r && req_valid_i) begin
            req_ready_r <= 1'b0;
            addr_r      <= req_addr_i;
            size_r      <= req_size_i;
            op_r        <= req_op_i;
            operand_r   <= req_operand_i;
            id_r        <= req_id_i;
            if (req_legal_s) begin
              ar_valid_r <= 1'b1;
              state_r    <= S_AR;
            end else begin
              rsp_valid_r <= 1'b1;
              rsp_err_r   <= 1'b1;
              rsp_data_r  <= 64'd0;
              state_r     <= S_RSP;
            end
          end else begin
            req_ready_r <= 1'b1;
          end
        end
        S_AR: begin
          if (mst_ar_ready_i) begin
            ar_valid_r <= 1'b0;
            r_ready_r  <= 1'b1;
            state_r    <= S_R;
          end
        end
        S_R: begin
          if (mst_r_valid_i) begin
            r_ready_r <= 1'b0;
            old_r     <= lane_s;
            if (mst_r_resp_i[1]) begin
              rsp_valid_r <= 1'b1;
              rsp_err_r   <= 1'b1;
              rsp_data_r  <= 64'd0;
              state_r     <= S_RSP;
            end else begin
              state_r <= S_ALU;
            end
          end
        end
        S_ALU: begin
          w_data_r   <= is_word_s ? {alu_s[31:0], alu_s[31:0]} : alu_s;
          w_strb_r   <= is_word_s ? (addr_r[2] ? 8'hF0 : 8'h0F) : 8'hFF;
          aw_valid_r <= 1'b1;
          w_valid_r  <= 1'b1;
          state_r    <= S_WR;
        end
        S_WR: begin
          if (aw_valid_r && mst_aw_ready_i) aw_valid_r <= 1'b0;
          if (w_valid_r && mst_w_ready_i) w_valid_r <= 1'b0;
          if (aw_done_s && w_done_s) begin
            b_ready_r <= 1'b1;
            state_r   <= S_B;
          end
        end
        S_B: begin
          if (mst_b_valid_i) begin
            b_ready_r   <= 1'b0;
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= mst_b_resp_i[1];
            rsp_data_r  <= old_r;
            state_r     <= S_RSP;
          end
        end
        S_RSP: begin
          if (rsp_ready_i) begin
            rsp_valid_r <= 1'b0;
            req_ready_r <= 1'b1;
            state_r     <= S_IDLE;
          end
        end
        default: begin
          req_ready_r <= 1'b0;
          rsp_valid_r <= 1'b0;
          ar_valid_r  <= 1'b0;
          r_ready_r   <= 1'b0;
          aw_valid_r  <= 1'b0;
          w_valid_r   <= 1'b0;
          b_ready_r   <= 1'b0;
          state_r     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o    = req_ready_r;
  assign rsp_valid_o    = rsp_valid_r;
  assign rsp_data_o     = rsp_data_r;
  assign rsp_err_o      = rsp_err_r;
  assign mst_ar_addr_o  = addr_r;
  assign mst_ar_size_o  = size_r;
  assign mst_ar_id_o    = id_r;
  assign mst_ar_valid_o = ar_valid_r;
  assign mst_r_ready_o  = r_ready_r;
  assign mst_aw_addr_o  = addr_r;
  assign mst_aw_size_o  = size_r;
  assign mst_aw_id_o    = id_r;
  assign mst_aw_valid_o = aw_valid_r;
  assign mst_w_data_o   = w_data_r;
  assign mst_w_strb_o   = w_strb_r;
  assign mst_w_last_o   = 1'b1;
  assign mst_w_valid_o  = w_valid_r;
  assign mst_b_ready_o  = b_ready_r;

endmodule
